mult_u: RTL and testbench



---
 rtl/mult_u_pkg.sv | 13 +
 rtl/mult_u_adder.sv | 12 +
 rtl/mult_u.sv | 93 +++++++++
 tb/tb_mult_u.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mult_u_pkg.sv
// rtl/mult_u_pkg.sv - shared types and constants for the shift-and-add multiplier
package mult_u_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = $clog2(DEF_WIDTH + 1);

endpackage

// File: rtl/mult_u_adder.sv
// rtl/mult_u_adder.sv - WIDTH-bit adder, carry out discarded
module mult_u_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] sum
);

  assign sum = x + y;

endmodule

// File: rtl/mult_u.sv
// rtl/mult_u.sv - sequential unsigned multiplier, one multiplier bit per clock
module mult_u
  import mult_u_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             doMult,
  output logic [WIDTH-1:0] out,
  output logic             mult_done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sum;

  mult_u_adder #(.WIDTH(WIDTH)) u_adder (
    .x   (acc_q),
    .y   (mcand_q),
    .sum (sum)
  );

  // Counter runs WIDTH..0; the edge that finds it at zero publishes the result,
  // which places mult_done WIDTH+1 edges after the start edge.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    done_d   = done_q;
    case (state_q)
      IDLE, DONE: begin
        if (doMult) begin
          mcand_d  = a;
          mplier_d = b;
          acc_d    = '0;
          cnt_d    = CNT_W'(WIDTH);
          done_d   = 1'b0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          if (mplier_q[0]) acc_d = sum;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q - CNT_W'(1);
        end else begin
          out_d   = acc_q;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      done_q   <= done_d;
    end
  end

  assign out       = out_q;
  assign mult_done = done_q;

endmodule

// File: tb/tb_mult_u.sv
// tb/tb_mult_u.sv - scoreboard bench for mult_u
module tb_mult_u;

  logic        clk;
  logic        reset;
  logic [31:0] a;
  logic [31:0] b;
  logic        doMult;
  logic [31:0] out;
  logic        mult_done;

  int          vectors;
  int          miscompares;
  logic [31:0] exp_q[$];
  logic [31:0] last_out;

  mult_u #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .a         (a),
    .b         (b),
    .doMult    (doMult),
    .out       (out),
    .mult_done (mult_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Starts one operation, optionally scrambles operands or re-pulses doMult
  // during BUSY, then checks latency, BUSY stability and the popped result.
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] expv, input bit scramble,
                        input bit repulse, input string name);
    int          edges;
    bit          busy_ok;
    logic [31:0] want;
    @(negedge clk);
    a      = av;
    b      = bv;
    doMult = 1'b1;
    exp_q.push_back(expv);
    @(posedge clk);
    #1;
    doMult  = 1'b0;
    edges   = 0;
    busy_ok = 1'b1;
    while (!mult_done && edges < 100) begin
      @(posedge clk);
      edges++;
      #1;
      if (scramble) begin
        a = $urandom;
        b = $urandom;
      end
      if (repulse && edges == 10) doMult = 1'b1;
      if (repulse && edges == 11) doMult = 1'b0;
      if (!mult_done && out !== last_out) busy_ok = 1'b0;
    end
    vectors++;
    if (edges !== 33) begin
      miscompares++;
      $display("FAIL %s latency: got %0d edges, expected 33", name, edges);
    end
    vectors++;
    if (!busy_ok) begin
      miscompares++;
      $display("FAIL %s busy_hold: out changed during BUSY (prior %h)", name, last_out);
    end
    want = exp_q.pop_front();
    vectors++;
    if (out !== want) begin
      miscompares++;
      $display("FAIL %s result: got %h, expected %h", name, out, want);
    end
    last_out = out;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    a      = '0;
    b      = '0;
    doMult = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (out !== 32'h0 || mult_done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: out=%h done=%b, expected out=0 done=0", out, mult_done);
    end
    last_out = 32'h0;
  endtask

  task automatic test_basic();
    run_op(32'd2, 32'd5, 32'h0000000A, 1'b0, 1'b0, "a2_b5");
  endtask

  task automatic test_done_hold();
    repeat (4) @(negedge clk);
    vectors++;
    if (out !== last_out || mult_done !== 1'b1) begin
      miscompares++;
      $display("FAIL done_hold: out=%h done=%b, expected out=%h done=1", out, mult_done, last_out);
    end
  endtask

  task automatic test_operand_change();
    run_op(32'h03, 32'h69, 32'h0000013B, 1'b1, 1'b0, "a3_b69_scramble");
  endtask

  task automatic test_overflow();
    run_op(32'hFFFFFFFF, 32'h2, 32'hFFFFFFFE, 1'b0, 1'b0, "max_x2");
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, "max_x_max");
  endtask

  task automatic test_back_to_back();
    run_op(32'hFFFFFFFF, 32'hFFFFFFF0, 32'h00000010, 1'b0, 1'b0, "restart_from_done");
  endtask

  task automatic test_repulse_zero();
    run_op(32'h1234_5678, 32'h0000_0009, 32'hA3D7_0A38, 1'b0, 1'b1, "repulse_busy");
    run_op(32'h0, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, "zero_a");
  endtask

  task automatic test_random();
    logic [31:0] ra, rb, p;
    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom;
      p  = ra * rb;
      run_op(ra, rb, p, 1'b0, 1'b0, "random");
    end
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    a      = 32'h7;
    b      = 32'h9;
    doMult = 1'b1;
    @(posedge clk);
    #1;
    doMult = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    vectors++;
    if (out !== 32'h0 || mult_done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_async: out=%h done=%b, expected out=0 done=0", out, mult_done);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    vectors++;
    if (out !== 32'h0 || mult_done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: out=%h done=%b, expected out=0 done=0", out, mult_done);
    end
    last_out = 32'h0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_done_hold();
    test_operand_change();
    test_overflow();
    test_back_to_back();
    test_repulse_zero();
    test_random();
    test_reset_mid_op();
    run_op(32'd6, 32'd7, 32'd42, 1'b0, 1'b0, "after_reset");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
